// File: rtl/up_dim.sv
// Expands one reduced fuzzy membership sample into Dim1 then Dim2 beats on a single output port.
// Latency: Dim1 valid the cycle after input accept, Dim2 the cycle after Dim1 accept; 3 cycles/sample.
// Backpressure: outputs held while out_ready=0; in_ready only in IDLE (also in EMIT2 with UPDIM_BACK2BACK_EN).
module up_dim #(
  parameter int Offset       = 0,
  parameter int InData_limit = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [InData_limit-1:0] CutLine,
  input  logic [3:0]              InFlag,
  input  logic [InData_limit-1:0] InDim,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    OutSel,
  output logic [3:0]              OutFlag,
  output logic [InData_limit-1:0] OutDim,
  output logic [7:0]              SampleCnt
);

  localparam int W = InData_limit;
  localparam logic [3:0] FLAG_CONFLICT = 4'b0010;

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

  state_t         state_q, state_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           out_sel_q, out_sel_d;
  logic [3:0]     out_flag_q, out_flag_d;
  logic [W-1:0]   out_dim_q, out_dim_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [W-1:0]   cap_cut_q, cap_cut_d;
  logic [3:0]     cap_flag_q, cap_flag_d;
  logic [W-1:0]   cap_dim_q, cap_dim_d;

  // Offset only applies to samples that were shifted at reduction (flag bit 1 clear).
  function automatic logic [W-1:0] restore(input logic [3:0] flag, input logic [W-1:0] dim);
    if (!flag[1] && (Offset > 0)) return dim >> Offset;
    else return dim;
  endfunction

  function automatic logic [W-1:0] dim1_of(input logic [W-1:0] v, input logic [W-1:0] cut);
    return (v > cut) ? cut : v;
  endfunction

  function automatic logic [W-1:0] dim2_of(input logic [W-1:0] v, input logic [W-1:0] cut);
    return (v > cut) ? (v - cut) : '0;
  endfunction

  function automatic logic [3:0] flag1_of(input logic [3:0] flag);
    return (flag == FLAG_CONFLICT) ? 4'b0001 : flag;
  endfunction

  function automatic logic [3:0] flag2_of(input logic [3:0] flag);
    return (flag == FLAG_CONFLICT) ? 4'b0100 : flag;
  endfunction

  logic         in_fire, out_fire;
  logic [W-1:0] in_v, cap_v;

  assign in_v  = restore(InFlag, InDim);
  assign cap_v = restore(cap_flag_q, cap_dim_q);

`ifdef UPDIM_BACK2BACK_EN
  assign in_ready = in_ready_q | ((state_q == EMIT2) & out_ready);
`else
  assign in_ready = in_ready_q;
`endif

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    out_flag_d  = out_flag_q;
    out_dim_d   = out_dim_q;
    cnt_d       = cnt_q;
    cap_cut_d   = cap_cut_q;
    cap_flag_d  = cap_flag_q;
    cap_dim_d   = cap_dim_q;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_fire) begin
          cap_cut_d   = CutLine;
          cap_flag_d  = InFlag;
          cap_dim_d   = InDim;
          state_d     = EMIT1;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          out_sel_d   = 1'b0;
          out_dim_d   = dim1_of(in_v, CutLine);
          out_flag_d  = flag1_of(InFlag);
        end
      end
      EMIT1: begin
        if (out_fire) begin
          state_d    = EMIT2;
          out_sel_d  = 1'b1;
          out_dim_d  = dim2_of(cap_v, cap_cut_q);
          out_flag_d = flag2_of(cap_flag_q);
        end
      end
      EMIT2: begin
        if (out_fire) begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          // A new sample arriving with the Dim2 accept skips the IDLE bubble.
          if (in_fire) begin
            cap_cut_d   = CutLine;
            cap_flag_d  = InFlag;
            cap_dim_d   = InDim;
            state_d     = EMIT1;
            out_valid_d = 1'b1;
            out_sel_d   = 1'b0;
            out_dim_d   = dim1_of(in_v, CutLine);
            out_flag_d  = flag1_of(InFlag);
          end else begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sel_q   <= 1'b0;
      out_flag_q  <= '0;
      out_dim_q   <= '0;
      cnt_q       <= '0;
      cap_cut_q   <= '0;
      cap_flag_q  <= '0;
      cap_dim_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_flag_q  <= out_flag_d;
      out_dim_q   <= out_dim_d;
      cnt_q       <= cnt_d;
      cap_cut_q   <= cap_cut_d;
      cap_flag_q  <= cap_flag_d;
      cap_dim_q   <= cap_dim_d;
    end
  end

  assign out_valid = out_valid_q;
  assign OutSel    = out_sel_q;
  assign OutFlag   = out_flag_q;
  assign OutDim    = out_dim_q;
  assign SampleCnt = cnt_q;

endmodule

// File: tb/tb_up_dim.sv
// Directed bench for up_dim: one instance with Offset=0 and one with Offset=2 share all stimulus.
module tb_up_dim;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [9:0] CutLine;
  logic [3:0] InFlag;
  logic [9:0] InDim;

  logic       a_in_ready, a_out_valid, a_sel;
  logic [3:0] a_flag;
  logic [9:0] a_dim;
  logic [7:0] a_cnt;

  logic       b_in_ready, b_out_valid, b_sel;
  logic [3:0] b_flag;
  logic [9:0] b_dim;
  logic [7:0] b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  up_dim #(.Offset(0), .InData_limit(10)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .CutLine(CutLine), .InFlag(InFlag), .InDim(InDim),
    .out_valid(a_out_valid), .out_ready(out_ready), .OutSel(a_sel),
    .OutFlag(a_flag), .OutDim(a_dim), .SampleCnt(a_cnt)
  );

  up_dim #(.Offset(2), .InData_limit(10)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .CutLine(CutLine), .InFlag(InFlag), .InDim(InDim),
    .out_valid(b_out_valid), .out_ready(out_ready), .OutSel(b_sel),
    .OutFlag(b_flag), .OutDim(b_dim), .SampleCnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] c, input logic [3:0] f, input logic [9:0] d);
    chk("in_ready_before_send", {31'd0, a_in_ready}, 32'd1);
    CutLine  = c;
    InFlag   = f;
    InDim    = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic beat_a(input string tag, input logic sel, input logic [9:0] d, input logic [3:0] f);
    chk({tag, "_valid"}, {31'd0, a_out_valid}, 32'd1);
    chk({tag, "_sel"},   {31'd0, a_sel},       {31'd0, sel});
    chk({tag, "_dim"},   {22'd0, a_dim},       {22'd0, d});
    chk({tag, "_flag"},  {28'd0, a_flag},      {28'd0, f});
  endtask

  task automatic beat_b(input string tag, input logic sel, input logic [9:0] d, input logic [3:0] f);
    chk({tag, "_valid"}, {31'd0, b_out_valid}, 32'd1);
    chk({tag, "_sel"},   {31'd0, b_sel},       {31'd0, sel});
    chk({tag, "_dim"},   {22'd0, b_dim},       {22'd0, d});
    chk({tag, "_flag"},  {28'd0, b_flag},      {28'd0, f});
  endtask

  initial begin
    int ov_cnt;
    int done_cnt;
    int exp_ov;
    int exp_done;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    CutLine   = '0;
    InFlag    = '0;
    InDim     = '0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready",  {31'd0, a_in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_sel",       {31'd0, a_sel},       32'd0);
    chk("rst_flag",      {28'd0, a_flag},      32'd0);
    chk("rst_dim",       {22'd0, a_dim},       32'd0);
    chk("rst_cnt",       {24'd0, a_cnt},       32'd0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_first_clk", {31'd0, a_in_ready}, 32'd0);
    tick();
    chk("in_ready_after_first_clk", {31'd0, a_in_ready}, 32'd1);

    // 1: V above CutLine
    out_ready = 1'b1;
    send(10'd300, 4'b0001, 10'd500);
    beat_a("t1_d1", 1'b0, 10'd300, 4'b0001);
    chk("t1_in_ready_busy", {31'd0, a_in_ready}, 32'd0);
    tick();
    beat_a("t1_d2", 1'b1, 10'd200, 4'b0001);
    tick();
    chk("t1_idle_valid", {31'd0, a_out_valid}, 32'd0);
    chk("t1_cnt",        {24'd0, a_cnt},       32'd1);
    chk("t1_in_ready",   {31'd0, a_in_ready},  32'd1);

    // 2: conflict flag, V below CutLine
    send(10'd300, 4'b0010, 10'd120);
    beat_a("t2_d1", 1'b0, 10'd120, 4'b0001);
    tick();
    beat_a("t2_d2", 1'b1, 10'd0, 4'b0100);
    tick();

    // 3: offset restore (instance b) vs no offset (instance a)
    send(10'd100, 4'b0000, 10'd800);
    beat_b("t3a_b_d1", 1'b0, 10'd100, 4'b0000);
    beat_a("t3a_a_d1", 1'b0, 10'd100, 4'b0000);
    tick();
    beat_b("t3a_b_d2", 1'b1, 10'd100, 4'b0000);
    beat_a("t3a_a_d2", 1'b1, 10'd700, 4'b0000);
    tick();
    send(10'd100, 4'b0010, 10'd800);
    beat_b("t3b_b_d1", 1'b0, 10'd100, 4'b0001);
    tick();
    beat_b("t3b_b_d2", 1'b1, 10'd700, 4'b0100);
    tick();
    chk("t3_cnt_a", {24'd0, a_cnt}, 32'd4);
    chk("t3_cnt_b", {24'd0, b_cnt}, 32'd4);

    // 4: backpressure in EMIT1 with changing inputs
    send(10'd50, 4'b0011, 10'd90);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      InDim = 10'd999 - 10'(i);
      tick();
      beat_a("t4_hold", 1'b0, 10'd50, 4'b0011);
      chk("t4_in_ready", {31'd0, a_in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    beat_a("t4_d2", 1'b1, 10'd40, 4'b0011);
    tick();

    // V == CutLine boundary
    send(10'd200, 4'b0001, 10'd200);
    beat_a("teq_d1", 1'b0, 10'd200, 4'b0001);
    tick();
    beat_a("teq_d2", 1'b1, 10'd0, 4'b0001);
    tick();
    chk("teq_cnt", {24'd0, a_cnt}, 32'd6);

    // 5: throughput with in_valid held high, then saturation
    CutLine  = 10'd10;
    InFlag   = 4'b0001;
    InDim    = 10'd25;
    in_valid = 1'b1;
    ov_cnt   = 0;
    done_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (a_out_valid) ov_cnt++;
      if (a_out_valid && a_sel) done_cnt++;
      tick();
    end
`ifdef UPDIM_BACK2BACK_EN
    exp_ov   = 59;
    exp_done = 29;
`else
    exp_ov   = 40;
    exp_done = 20;
`endif
    chk("t5_valid_cycles", ov_cnt,   exp_ov);
    chk("t5_samples",      done_cnt, exp_done);
    chk("t5_cnt",          {24'd0, a_cnt}, 32'(6 + exp_done));
    for (int c = 0; c < 900; c++) tick();
    chk("t5_cnt_saturated", {24'd0, a_cnt}, 32'd255);
    in_valid = 1'b0;
    for (int i = 0; i < 4 && a_out_valid; i++) tick();
    chk("t5_drained", {31'd0, a_out_valid}, 32'd0);
    tick();

    // 6: reset during EMIT2
    send(10'd300, 4'b0001, 10'd500);
    tick();
    chk("t6_in_emit2", {31'd0, a_sel}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid",    {31'd0, a_out_valid}, 32'd0);
    chk("t6_rst_cnt",      {24'd0, a_cnt},       32'd0);
    chk("t6_rst_in_ready", {31'd0, a_in_ready},  32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_valid", {31'd0, a_out_valid}, 32'd0);
    send(10'd300, 4'b0001, 10'd500);
    beat_a("t6_d1", 1'b0, 10'd300, 4'b0001);
    tick();
    beat_a("t6_d2", 1'b1, 10'd200, 4'b0001);
    tick();
    chk("t6_cnt", {24'd0, a_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
